// File: rtl/move_button_conditioner_pkg.sv
// Shared types and constants for the move button conditioner.
// Direction indices double as arbitration priority: lower index wins.
package move_ctrl_pkg;

  localparam int NUM_DIRS = 4;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  // Default timing, 50 MHz clock: 20 ms debounce, 0.5 s first repeat, 0.1 s repeat period.
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  // One-hot mask of the lowest set bit of vec (all zeros when vec is empty).
  function automatic logic [NUM_DIRS-1:0] lowest_one(input logic [NUM_DIRS-1:0] vec);
    logic [NUM_DIRS-1:0] res;
    res = '0;
    for (int i = NUM_DIRS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        res    = '0;
        res[i] = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/move_button_conditioner_if.sv
// Button-side and cursor-side signals of the move button conditioner.
// master: the board/test side that drives buttons and enable.
// slave:  the conditioner itself.
interface move_button_conditioner_if;

  logic enable;
  logic btn_up_n;
  logic btn_down_n;
  logic btn_left_n;
  logic btn_right_n;
  logic move_up;
  logic move_down;
  logic move_left;
  logic move_right;
  logic busy;

  modport master (
    output enable, btn_up_n, btn_down_n, btn_left_n, btn_right_n,
    input  move_up, move_down, move_left, move_right, busy
  );

  modport slave (
    input  enable, btn_up_n, btn_down_n, btn_left_n, btn_right_n,
    output move_up, move_down, move_left, move_right, busy
  );

endinterface

// File: rtl/move_button_conditioner_debouncer.sv
// button_debouncer: 2-flop synchronizer, stability counter and press strobe
// for one raw active-low push-button.
// press_o is high on the clock whose edge moves the debounced level 1 -> 0.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  output logic level_o,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Bring the asynchronous button into the clk domain; reset to released.
  // NOTE: sequential state always uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive clocks the sample disagrees with the level; adopt it on the last one.
  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = level_q & ~level_d;

endmodule

// File: rtl/move_button_conditioner.sv
// move_button_conditioner: debounces four raw move buttons and turns each
// accepted press into one active-low, single-cycle move pulse, at most one
// direction per clock (up > down > left > right).
// Optional feature: define MOVE_BUTTON_AUTO_REPEAT_EN to re-issue moves while
// a button stays held (first after REPEAT_DELAY, then every REPEAT_PERIOD).
module move_button_conditioner
  import move_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                      clk,
  input  logic                      rst,
  move_button_conditioner_if.slave  io
);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("move_button_conditioner: timing parameters must be at least 1");
  end

  logic [NUM_DIRS-1:0] btn_n;
  logic [NUM_DIRS-1:0] level;
  logic [NUM_DIRS-1:0] press;
  logic [NUM_DIRS-1:0] rpt_fire;
  logic [NUM_DIRS-1:0] set_mask;
  logic [NUM_DIRS-1:0] grant;
  logic [NUM_DIRS-1:0] pending_q, pending_d;
  logic [NUM_DIRS-1:0] move_n_q, move_n_d;

  assign btn_n[DIR_UP]    = io.btn_up_n;
  assign btn_n[DIR_DOWN]  = io.btn_down_n;
  assign btn_n[DIR_LEFT]  = io.btn_left_n;
  assign btn_n[DIR_RIGHT] = io.btn_right_n;

  for (genvar gi = 0; gi < NUM_DIRS; gi++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk     (clk),
      .rst_n   (rst),
      .btn_n_i (btn_n[gi]),
      .level_o (level[gi]),
      .press_o (press[gi])
    );
  end

`ifdef MOVE_BUTTON_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [RPT_W-1:0] RPT_ONE     = RPT_W'(1);

  logic [RPT_W-1:0]    rpt_cnt_q [NUM_DIRS];
  logic [RPT_W-1:0]    rpt_cnt_d [NUM_DIRS];
  logic [NUM_DIRS-1:0] rpt_active_q, rpt_active_d;
  logic [NUM_DIRS-1:0] rpt_first_q, rpt_first_d;

  // Per-direction repeat timer: armed by an accepted press, cleared by release or enable low.
  always_comb begin
    rpt_fire     = '0;
    rpt_active_d = rpt_active_q;
    rpt_first_d  = rpt_first_q;
    for (int i = 0; i < NUM_DIRS; i++) begin
      rpt_cnt_d[i] = rpt_cnt_q[i];
      if (io.enable && press[i]) begin
        rpt_active_d[i] = 1'b1;
        rpt_first_d[i]  = 1'b1;
        rpt_cnt_d[i]    = '0;
      end else if (!io.enable || level[i]) begin
        rpt_active_d[i] = 1'b0;
        rpt_first_d[i]  = 1'b0;
        rpt_cnt_d[i]    = '0;
      end else if (rpt_active_q[i]) begin
        if (rpt_cnt_q[i] == (rpt_first_q[i] ? DELAY_LAST : PERIOD_LAST)) begin
          rpt_fire[i]    = 1'b1;
          rpt_first_d[i] = 1'b0;
          rpt_cnt_d[i]   = '0;
        end else begin
          rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_ONE;
        end
      end
    end
  end

  // Repeat timer registers.
  // NOTE: the counter array is a handful of flops, not a RAM, so every entry is reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_active_q <= '0;
      rpt_first_q  <= '0;
      for (int i = 0; i < NUM_DIRS; i++) begin
        rpt_cnt_q[i] <= '0;
      end
    end else begin
      rpt_active_q <= rpt_active_d;
      rpt_first_q  <= rpt_first_d;
      for (int i = 0; i < NUM_DIRS; i++) begin
        rpt_cnt_q[i] <= rpt_cnt_d[i];
      end
    end
  end
`else
  // Without repeats a held button yields a single pulse; the level has no consumer.
  logic unused_level;
  assign unused_level = &{1'b0, level};
  assign rpt_fire     = '0;
`endif

  // Serve the lowest pending direction; new sets win over the clear of a served bit.
  always_comb begin
    grant     = io.enable ? lowest_one(pending_q) : '0;
    set_mask  = (press & {NUM_DIRS{io.enable}}) | rpt_fire;
    pending_d = io.enable ? ((pending_q & ~grant) | set_mask) : '0;
    move_n_d  = ~grant;
  end

  // Pending flags and registered active-low move outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
      move_n_q  <= '1;
    end else begin
      pending_q <= pending_d;
      move_n_q  <= move_n_d;
    end
  end

  assign io.move_up    = move_n_q[DIR_UP];
  assign io.move_down  = move_n_q[DIR_DOWN];
  assign io.move_left  = move_n_q[DIR_LEFT];
  assign io.move_right = move_n_q[DIR_RIGHT];
  assign io.busy       = |pending_q;

endmodule

// File: tb/tb_move_button_conditioner.sv
// Bench for move_button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8. Expected pulses (direction, edge number) are queued when
// stimulus is driven and matched by the monitor as pulses appear.
module tb_move_button_conditioner;
  import move_ctrl_pkg::*;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;
  localparam int LAT = 2 + DEB + 1;

  typedef struct {
    int dir;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   pulse_cnt = 0;
  int   onehot_err = 0;
  exp_t exp_q[$];
  logic [3:0] moves;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  move_button_conditioner_if io ();

  move_button_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  assign moves = {io.move_right, io.move_left, io.move_down, io.move_up};

  // Scoreboard side: every observed low move bit must be the next expected pulse.
  always @(negedge clk) begin
    exp_t e;
    if ($countones(~moves) > 1) onehot_err++;
    for (int i = 0; i < NUM_DIRS; i++) begin
      if (moves[i] === 1'b0) begin
        pulse_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL pulse: got dir %0d at edge %0d, required no pulse", i, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.dir === i && e.cyc === cyc) n_pass++;
          else $display("FAIL pulse: got dir %0d at edge %0d, required dir %0d at edge %0d",
                        i, cyc, e.dir, e.cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input dir_t d, input int edge_no);
    exp_t e;
    e.dir = int'(d);
    e.cyc = edge_no;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    int base, p0;
    rst = 1'b0;
    io.enable = 1'b1;
    io.btn_up_n = 1'b1; io.btn_down_n = 1'b1; io.btn_left_n = 1'b1; io.btn_right_n = 1'b1;
    tick(3);
    n_checks++;
    if (moves !== 4'hF) $display("FAIL reset_moves: got %b, required 1111", moves);
    else n_pass++;
    n_checks++;
    if (io.busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", io.busy);
    else n_pass++;
    p0 = pulse_cnt;
    io.btn_up_n = 1'b0;
    rst = 1'b1;
    base = cyc;
    expect_pulse(DIR_UP, base + LAT);
    tick(12);
    io.btn_up_n = 1'b1;
    tick(10);
    n_checks++;
    if (pulse_cnt - p0 !== 1) $display("FAIL reset_held_pulses: got %0d, required 1", pulse_cnt - p0);
    else n_pass++;
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL reset_missing: got %0d outstanding, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_clean_press();
    int base, p0;
    p0 = pulse_cnt;
    io.btn_right_n = 1'b0;
    base = cyc;
    expect_pulse(DIR_RIGHT, base + LAT);
    tick(LAT - 1);
    n_checks++;
    if (io.busy !== 1'b1) $display("FAIL clean_busy_set: got %b, required 1", io.busy);
    else n_pass++;
    tick(1);
    n_checks++;
    if (io.busy !== 1'b0) $display("FAIL clean_busy_clear: got %b, required 0", io.busy);
    else n_pass++;
    tick(10 - LAT);
    io.btn_right_n = 1'b1;
    tick(12);
    n_checks++;
    if (pulse_cnt - p0 !== 1) $display("FAIL clean_pulses: got %0d, required 1", pulse_cnt - p0);
    else n_pass++;
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL clean_missing: got %0d outstanding, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_bounce();
    int p0;
    p0 = pulse_cnt;
    io.btn_left_n = 1'b0; tick(3);
    io.btn_left_n = 1'b1; tick(2);
    io.btn_left_n = 1'b0; tick(3);
    io.btn_left_n = 1'b1; tick(12);
    n_checks++;
    if (pulse_cnt - p0 !== 0) $display("FAIL bounce_pulses: got %0d, required 0", pulse_cnt - p0);
    else n_pass++;
    n_checks++;
    if (io.busy !== 1'b0) $display("FAIL bounce_busy: got %b, required 0", io.busy);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    int base, p0;
    p0 = pulse_cnt;
    io.btn_down_n = 1'b0;
    io.btn_up_n   = 1'b0;
    base = cyc;
    expect_pulse(DIR_UP,   base + LAT);
    expect_pulse(DIR_DOWN, base + LAT + 1);
    tick(LAT);
    n_checks++;
    if (io.busy !== 1'b1) $display("FAIL simul_busy_hold: got %b, required 1", io.busy);
    else n_pass++;
    tick(1);
    n_checks++;
    if (io.busy !== 1'b0) $display("FAIL simul_busy_clear: got %b, required 0", io.busy);
    else n_pass++;
    tick(4);
    io.btn_down_n = 1'b1;
    io.btn_up_n   = 1'b1;
    tick(12);
    n_checks++;
    if (pulse_cnt - p0 !== 2) $display("FAIL simul_pulses: got %0d, required 2", pulse_cnt - p0);
    else n_pass++;
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL simul_missing: got %0d outstanding, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_enable_gating();
    int base, p0;
    p0 = pulse_cnt;
    io.enable   = 1'b0;
    io.btn_up_n = 1'b0;
    tick(10);
    io.enable = 1'b1;
    tick(5);
    n_checks++;
    if (io.busy !== 1'b0) $display("FAIL gate_busy: got %b, required 0", io.busy);
    else n_pass++;
    io.btn_up_n = 1'b1;
    tick(10);
    n_checks++;
    if (pulse_cnt - p0 !== 0) $display("FAIL gate_no_pulse: got %0d, required 0", pulse_cnt - p0);
    else n_pass++;
    io.btn_up_n = 1'b0;
    base = cyc;
    expect_pulse(DIR_UP, base + LAT);
    tick(10);
    io.btn_up_n = 1'b1;
    tick(12);
    n_checks++;
    if (pulse_cnt - p0 !== 1) $display("FAIL gate_repress: got %0d, required 1", pulse_cnt - p0);
    else n_pass++;
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL gate_missing: got %0d outstanding, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_press();
    int base, p0;
    p0 = pulse_cnt;
    io.btn_right_n = 1'b0;
    tick(LAT - 1);
    n_checks++;
    if (io.busy !== 1'b1) $display("FAIL midrst_busy_before: got %b, required 1", io.busy);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (io.busy !== 1'b0) $display("FAIL midrst_busy: got %b, required 0", io.busy);
    else n_pass++;
    n_checks++;
    if (moves !== 4'hF) $display("FAIL midrst_moves: got %b, required 1111", moves);
    else n_pass++;
    tick(2);
    rst = 1'b1;
    base = cyc;
    expect_pulse(DIR_RIGHT, base + LAT);
    tick(10);
    io.btn_right_n = 1'b1;
    tick(12);
    n_checks++;
    if (pulse_cnt - p0 !== 1) $display("FAIL midrst_pulses: got %0d, required 1", pulse_cnt - p0);
    else n_pass++;
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL midrst_missing: got %0d outstanding, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_auto_repeat();
    int base, p0, n_exp;
    p0 = pulse_cnt;
    io.btn_down_n = 1'b0;
    base = cyc;
    expect_pulse(DIR_DOWN, base + LAT);
    n_exp = 1;
`ifdef MOVE_BUTTON_AUTO_REPEAT_EN
    expect_pulse(DIR_DOWN, base + LAT + RD);
    expect_pulse(DIR_DOWN, base + LAT + RD + RP);
    expect_pulse(DIR_DOWN, base + LAT + RD + 2 * RP);
    n_exp = 4;
`endif
    tick(40);
    io.btn_down_n = 1'b1;
    tick(15);
    n_checks++;
    if (pulse_cnt - p0 !== n_exp) $display("FAIL repeat_pulses: got %0d, required %0d", pulse_cnt - p0, n_exp);
    else n_pass++;
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL repeat_missing: got %0d outstanding, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_one_hot();
    n_checks++;
    if (onehot_err !== 0) $display("FAIL one_hot: got %0d multi-pulse cycles, required 0", onehot_err);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_enable_gating();
    test_reset_mid_press();
    test_auto_repeat();
    test_one_hot();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
